// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: one-hot operation codes (common
// with the control decoder) and the sequencing state encoding.
package ula_pkg;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0010;
  localparam logic [3:0] ALU_DIV = 4'b0001;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/ula_passo_div.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits, and emit the quotient bit.
module ula_passo_div
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] parcial;
  logic [WIDTH:0] diferenca;

  assign parcial   = {rem_i, bit_i};
  assign diferenca = parcial - {1'b0, divisor_i};
  assign q_o       = (parcial >= {1'b0, divisor_i});
  // The restored remainder is always below the divisor, so WIDTH bits suffice.
  assign rem_o     = q_o ? diferenca[WIDTH-1:0] : parcial[WIDTH-1:0];

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle add/sub, bit-serial shift-add mul and restoring div
// with a Start/Busy/Done handshake. Define ULA_OVERFLOW_EN to build the Overflow flag.
module ula_multiciclo
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [3:0]       ALUCode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [3:0]             op_q, op_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       result_q, result_d, rem_q, rem_d;
  logic                   busy_q, done_q, divzero_q, divzero_d;

  logic [WIDTH-1:0]       soma, diferenca;
  logic [WIDTH:0]         soma_mul;
  logic [2*WIDTH-1:0]     mul_prox, div_prox;
  logic [WIDTH-1:0]       div_rem;
  logic                   div_q;
  logic                   ultimo;

  assign soma      = A + B;
  assign diferenca = A - B;
  assign ultimo    = (cnt_q == CW'(1));

  // Accumulator holds {high product, multiplier} for mul and {remainder, dividend/quotient} for div.
  assign soma_mul = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_prox = {soma_mul, acc_q[WIDTH-1:1]};

  ula_passo_div #(.WIDTH(WIDTH)) u_passo (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .q_o       (div_q)
  );

  assign div_prox = {div_rem, acc_q[WIDTH-2:0], div_q};

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start)
              state_d = ((ALUCode == ALU_MUL) || (ALUCode == ALU_DIV && B != '0)) ? CALC : DONE;
      CALC: if (ultimo) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    rem_d     = rem_q;
    divzero_d = divzero_q;
    case (state_q)
      IDLE: if (Start) begin
        op_d      = ALUCode;
        opnd_d    = (ALUCode == ALU_MUL) ? A : B;
        cnt_d     = CW'(WIDTH);
        divzero_d = 1'b0;
        case (ALUCode)
          ALU_ADD: begin result_d = soma;      rem_d = '0; end
          ALU_SUB: begin result_d = diferenca; rem_d = '0; end
          ALU_MUL: acc_d = {{WIDTH{1'b0}}, B};
          ALU_DIV: begin
            if (B == '0) begin
              result_d  = '1;
              rem_d     = A;
              divzero_d = 1'b1;
            end else begin
              acc_d = {{WIDTH{1'b0}}, A};
            end
          end
          default: begin result_d = '0; rem_d = '0; end
        endcase
      end
      CALC: begin
        cnt_d = cnt_q - CW'(1);
        acc_d = (op_q == ALU_MUL) ? mul_prox : div_prox;
        if (ultimo) begin
          if (op_q == ALU_MUL) begin
            result_d = mul_prox[WIDTH-1:0];
            rem_d    = '0;
          end else begin
            result_d = div_prox[WIDTH-1:0];
            rem_d    = div_prox[2*WIDTH-1:WIDTH];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      result_q  <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      rem_q     <= rem_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      divzero_q <= divzero_d;
    end
  end

  always_ff @(posedge Clock) begin
    acc_q  <= acc_d;
    opnd_q <= opnd_d;
    op_q   <= op_d;
    cnt_q  <= cnt_d;
  end

  assign Result    = result_q;
  assign Remainder = rem_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivZero   = divzero_q;

`ifdef ULA_OVERFLOW_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && Start) begin
      case (ALUCode)
        ALU_ADD: ovf_d = (A[WIDTH-1] == B[WIDTH-1]) && (soma[WIDTH-1] != A[WIDTH-1]);
        ALU_SUB: ovf_d = (A[WIDTH-1] != B[WIDTH-1]) && (diferenca[WIDTH-1] != A[WIDTH-1]);
        default: ovf_d = 1'b0;
      endcase
    end else if (state_q == CALC && ultimo && op_q == ALU_MUL) begin
      ovf_d = |mul_prox[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign Overflow = ovf_q;
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo (WIDTH=8).
module tb_ula_multiciclo;
  import ula_pkg::*;

  localparam int W = 8;

`ifdef ULA_OVERFLOW_EN
  localparam int OVF = 1;
`else
  localparam int OVF = 0;
`endif

  logic         Clock = 1'b0;
  logic         Resetn = 1'b0;
  logic         Start = 1'b0;
  logic [3:0]   ALUCode = 4'b0000;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Result, Remainder;
  logic         Busy, Done, DivZero, Overflow;

  int n_chk  = 0;
  int n_fail = 0;

  ula_multiciclo #(.WIDTH(W)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Start     (Start),
    .ALUCode   (ALUCode),
    .A         (A),
    .B         (B),
    .Result    (Result),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Overflow  (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Waits for the DUT to be idle, then presents one request sampled on the next edge.
  task automatic start_op(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    int guard;
    guard = 0;
    @(negedge Clock);
    while (Busy && guard < 40) begin
      @(negedge Clock);
      guard++;
    end
    ALUCode = code;
    A       = a;
    B       = b;
    Start   = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
  endtask

  // lat counts edges from the sampling edge (1) until Done is seen.
  task automatic wait_done(input string tag, input int lat0, input int exp_lat);
    int lat;
    bit busy_ok;
    lat     = lat0;
    busy_ok = 1'b1;
    while (!Done && lat < 40) begin
      if (!Busy) busy_ok = 1'b0;
      @(posedge Clock);
      #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_busy"}, 32'(busy_ok && Busy), 1);
  endtask

  task automatic finish_op(input string tag, input int r, input int rm, input int dz, input int ov);
    check_eq({tag, "_res"}, 32'(Result), r);
    check_eq({tag, "_rem"}, 32'(Remainder), rm);
    check_eq({tag, "_dz"}, 32'(DivZero), dz);
    check_eq({tag, "_ovf"}, 32'(Overflow), ov);
    @(posedge Clock);
    #1;
    check_eq({tag, "_busy_off"}, 32'(Busy), 0);
    check_eq({tag, "_done_off"}, 32'(Done), 0);
    check_eq({tag, "_hold"}, 32'(Result), r);
  endtask

  initial begin
    int pulses;

    #12;
    check_eq("rst_res", 32'(Result), 0);
    check_eq("rst_rem", 32'(Remainder), 0);
    check_eq("rst_busy", 32'(Busy), 0);
    check_eq("rst_done", 32'(Done), 0);
    check_eq("rst_dz", 32'(DivZero), 0);
    check_eq("rst_ovf", 32'(Overflow), 0);
    @(negedge Clock);
    Resetn = 1'b1;

    start_op(ALU_ADD, 8'd100, 8'd50);
    wait_done("add", 1, 1);
    finish_op("add", 150, 0, 0, OVF);

    start_op(ALU_SUB, 8'd5, 8'd7);
    wait_done("sub", 1, 1);
    finish_op("sub", 254, 0, 0, 0);

    start_op(ALU_MUL, 8'd13, 8'd11);
    wait_done("mul1", 1, 9);
    finish_op("mul1", 143, 0, 0, 0);

    start_op(ALU_MUL, 8'd20, 8'd20);
    wait_done("mul2", 1, 9);
    finish_op("mul2", 144, 0, 0, OVF);

    start_op(ALU_DIV, 8'd100, 8'd7);
    wait_done("div", 1, 9);
    finish_op("div", 14, 2, 0, 0);

    start_op(ALU_DIV, 8'd9, 8'd0);
    wait_done("div0", 1, 1);
    finish_op("div0", 255, 9, 1, 0);

    start_op(4'b0000, 8'd3, 8'd4);
    wait_done("ilg", 1, 1);
    finish_op("ilg", 0, 0, 0, 0);

    // A second request with new operands mid-multiply must be dropped.
    start_op(ALU_MUL, 8'd13, 8'd11);
    @(negedge Clock);
    @(negedge Clock);
    ALUCode = ALU_ADD;
    A       = 8'd1;
    B       = 8'd2;
    Start   = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    wait_done("ign", 3, 9);
    finish_op("ign", 143, 0, 0, 0);

    start_op(ALU_SUB, 8'd9, 8'd4);
    wait_done("b2b", 1, 1);
    finish_op("b2b", 5, 0, 0, 0);

    // Asynchronous reset in the middle of a division.
    start_op(ALU_DIV, 8'd100, 8'd7);
    @(posedge Clock);
    @(posedge Clock);
    #3;
    Resetn = 1'b0;
    #1;
    check_eq("mrst_res", 32'(Result), 0);
    check_eq("mrst_busy", 32'(Busy), 0);
    check_eq("mrst_done", 32'(Done), 0);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge Clock);
      #1;
      if (Done) pulses++;
    end
    check_eq("mrst_no_done", pulses, 0);
    check_eq("mrst_idle", 32'(Busy), 0);

    start_op(ALU_DIV, 8'd100, 8'd7);
    wait_done("div_rst", 1, 9);
    finish_op("div_rst", 14, 2, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
